// File: rtl/amber_irq_vector_scheduler.sv
// Amber IRQ/FIRQ vector scheduler: per-class arbitration, claim/EOI handshake and
// a small Wishbone register window in front of the core's o_irq/o_firq inputs.

package amber_irq_vector_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [15:0] ADR_IRQ_CLAIM  = 16'h0000;
    localparam logic [15:0] ADR_FIRQ_CLAIM = 16'h0004;
    localparam logic [15:0] ADR_IRQ_EOI    = 16'h0008;
    localparam logic [15:0] ADR_FIRQ_EOI   = 16'h000C;
    localparam logic [15:0] ADR_MODE       = 16'h0010;
    localparam logic [15:0] ADR_STATUS     = 16'h0014;
    localparam logic [15:0] ADR_ERR_CLR    = 16'h0018;

    localparam logic [31:0] UNMAPPED_WORD  = 32'h22334455;

endpackage

// One interrupt class: arbiter, round-robin pointer and IDLE/PEND/SERVICE handshake.
module amber_irq_vector_class
    import amber_irq_vector_scheduler_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_status,
    input  logic               i_rr_mode,
    input  logic               i_claim,
    input  logic               i_eoi,
    input  logic [4:0]         i_eoi_vec,
    output logic [1:0]         o_state,
    output logic [4:0]         o_vec,
    output logic               o_req,
    output logic [31:0]        o_claim_word,
    output logic               o_err
);

    irq_state_e state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [4:0] ptr_q, ptr_d;
    logic [4:0] arb_vec;
    logic       arb_hit;

    function automatic logic [4:0] wrap_inc(input logic [4:0] v);
        return (v == 5'(NUM_SRC - 1)) ? 5'd0 : v + 5'd1;
    endfunction

    // Search starts at the pointer in round-robin mode and at 0 in fixed mode.
    always_comb begin
        int idx;
        arb_vec = '0;
        arb_hit = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = i + (i_rr_mode ? int'(ptr_q) : 0);
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!arb_hit && i_status[idx]) begin
                arb_hit = 1'b1;
                arb_vec = idx[4:0];
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        ptr_d        = ptr_q;
        o_err        = 1'b0;
        o_claim_word = '0;
        unique case (state_q)
            ST_IDLE: begin
                vec_d = arb_vec;
                o_err = i_eoi;
                if (|i_status) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                vec_d = arb_vec;
                o_err = i_eoi;
                if (i_claim) begin
                    state_d      = ST_SERVICE;
                    vec_d        = vec_q;
                    o_claim_word = {1'b1, 26'd0, vec_q};
                    if (i_rr_mode) begin
                        ptr_d = wrap_inc(vec_q);
                    end
                end else if (!(|i_status)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_eoi) begin
                    if (i_eoi_vec == vec_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        o_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_state = state_q;
    assign o_vec   = vec_q;
    assign o_req   = (state_q == ST_PEND);

endmodule

module amber_irq_vector_scheduler
    import amber_irq_vector_scheduler_pkg::*;
#(
    parameter int WB_DWIDTH = 32,
    parameter int WB_SWIDTH = 4,
    parameter int NUM_SRC   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_SRC-1:0]   i_irq_status,
    input  logic [NUM_SRC-1:0]   i_firq_status,
    input  logic [31:0]          i_wb_adr,
    input  logic [WB_SWIDTH-1:0] i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic                 o_wb_ack,
    output logic                 o_wb_err,
    output logic                 o_irq,
    output logic                 o_firq
);

    logic        start_read_q, start_read_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  mode_q, mode_d;
    logic        err_q, err_d;

    logic        start_write, start_read;
    logic [15:0] adr;
    logic [31:0] wdata;

    logic [1:0]  irq_state, firq_state;
    logic [4:0]  irq_vec, firq_vec;
    logic [31:0] irq_claim_word, firq_claim_word;
    logic        irq_err, firq_err;
    logic        irq_claim, firq_claim, irq_eoi, firq_eoi;
    logic        unused_inputs;

    // A held strobe cannot start a second read while the first ack is still pending.
    assign start_write = i_wb_stb &  i_wb_we & ~start_read_q;
    assign start_read  = i_wb_stb & ~i_wb_we & ~start_read_q;
    assign adr         = i_wb_adr[15:0];

    generate
        if (WB_DWIDTH == 128) begin : g_wide
            assign wdata = i_wb_dat[32*i_wb_adr[3:2] +: 32];
        end else begin : g_narrow
            assign wdata = i_wb_dat[31:0];
        end
    endgenerate

    assign irq_claim  = start_read  && (adr == ADR_IRQ_CLAIM);
    assign firq_claim = start_read  && (adr == ADR_FIRQ_CLAIM);
    assign irq_eoi    = start_write && (adr == ADR_IRQ_EOI);
    assign firq_eoi   = start_write && (adr == ADR_FIRQ_EOI);

    amber_irq_vector_class #(.NUM_SRC(NUM_SRC)) u_irq_class (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_status     (i_irq_status),
        .i_rr_mode    (mode_q[0]),
        .i_claim      (irq_claim),
        .i_eoi        (irq_eoi),
        .i_eoi_vec    (wdata[4:0]),
        .o_state      (irq_state),
        .o_vec        (irq_vec),
        .o_req        (o_irq),
        .o_claim_word (irq_claim_word),
        .o_err        (irq_err)
    );

    amber_irq_vector_class #(.NUM_SRC(NUM_SRC)) u_firq_class (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_status     (i_firq_status),
        .i_rr_mode    (mode_q[1]),
        .i_claim      (firq_claim),
        .i_eoi        (firq_eoi),
        .i_eoi_vec    (wdata[4:0]),
        .o_state      (firq_state),
        .o_vec        (firq_vec),
        .o_req        (o_firq),
        .o_claim_word (firq_claim_word),
        .o_err        (firq_err)
    );

    always_comb begin
        start_read_d = start_read;
        rdata_d      = rdata_q;
        mode_d       = mode_q;
        err_d        = err_q | irq_err | firq_err;

        if (start_write) begin
            if (adr == ADR_MODE) begin
                mode_d = wdata[1:0];
            end
            if (adr == ADR_ERR_CLR) begin
                err_d = 1'b0;
            end
        end

        if (start_read) begin
            unique case (adr)
                ADR_IRQ_CLAIM:  rdata_d = irq_claim_word;
                ADR_FIRQ_CLAIM: rdata_d = firq_claim_word;
                ADR_MODE:       rdata_d = {30'd0, mode_q};
                ADR_STATUS:     rdata_d = {15'd0, err_q, 2'd0, firq_vec, irq_vec,
                                           firq_state, irq_state};
                default:        rdata_d = UNMAPPED_WORD;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_read_q <= 1'b0;
            rdata_q      <= '0;
            mode_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            start_read_q <= start_read_d;
            rdata_q      <= rdata_d;
            mode_q       <= mode_d;
            err_q        <= err_d;
        end
    end

    assign o_wb_dat = {(WB_DWIDTH/32){rdata_q}};
    assign o_wb_ack = start_write | start_read_q;
    assign o_wb_err = 1'b0;

    assign unused_inputs = ^{i_wb_sel, i_wb_cyc, i_wb_adr[31:16], wdata[31:5]};

endmodule

// File: tb/tb_amber_irq_vector_scheduler.sv
// Directed bench for amber_irq_vector_scheduler: claim/EOI flow, round-robin order,
// short status pulses, class nesting and reset during service.

module tb_amber_irq_vector_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_irq_status;
    logic [31:0] i_firq_status;
    logic [31:0] i_wb_adr;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic        o_irq;
    logic        o_firq;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_IRQ_CLAIM  = 32'h00;
    localparam logic [31:0] A_FIRQ_CLAIM = 32'h04;
    localparam logic [31:0] A_IRQ_EOI    = 32'h08;
    localparam logic [31:0] A_MODE       = 32'h10;
    localparam logic [31:0] A_STATUS     = 32'h14;
    localparam logic [31:0] A_ERR_CLR    = 32'h18;

    amber_irq_vector_scheduler #(
        .WB_DWIDTH (32),
        .WB_SWIDTH (4),
        .NUM_SRC   (32)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_irq_status  (i_irq_status),
        .i_firq_status (i_firq_status),
        .i_wb_adr      (i_wb_adr),
        .i_wb_sel      (i_wb_sel),
        .i_wb_we       (i_wb_we),
        .i_wb_dat      (i_wb_dat),
        .o_wb_dat      (o_wb_dat),
        .i_wb_cyc      (i_wb_cyc),
        .i_wb_stb      (i_wb_stb),
        .o_wb_ack      (o_wb_ack),
        .o_wb_err      (o_wb_err),
        .o_irq         (o_irq),
        .o_firq        (o_firq)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Read: ack and data appear one cycle after the strobe, then one idle cycle.
    task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        i_wb_adr = adr;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        tick();
        check({tag, "_ack"}, {31'd0, o_wb_ack}, 32'd1);
        check(tag, o_wb_dat, exp);
        i_wb_stb = 1'b0;
        i_wb_cyc = 1'b0;
        tick();
    endtask

    // Write: ack in the strobe cycle, takes effect at the following edge.
    task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat);
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        #1;
        check({tag, "_ack"}, {31'd0, o_wb_ack}, 32'd1);
        @(posedge i_clk);
        #1;
        i_wb_stb = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    initial begin
        logic [4:0] rr_exp [4];
        rr_exp[0] = 5'd1;
        rr_exp[1] = 5'd2;
        rr_exp[2] = 5'd1;
        rr_exp[3] = 5'd2;

        i_rst         = 1'b1;
        i_irq_status  = '0;
        i_firq_status = '0;
        i_wb_adr      = '0;
        i_wb_sel      = 4'hF;
        i_wb_we       = 1'b0;
        i_wb_dat      = '0;
        i_wb_cyc      = 1'b0;
        i_wb_stb      = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_irq",  {31'd0, o_irq},    32'd0);
        check("rst_firq", {31'd0, o_firq},   32'd0);
        check("rst_ack",  {31'd0, o_wb_ack}, 32'd0);
        check("rst_dat",  o_wb_dat,          32'd0);
        check("rst_err",  {31'd0, o_wb_err}, 32'd0);
        i_rst = 1'b0;
        tick();
        wb_read("rst_status", A_STATUS, 32'h0000_0000);
        wb_read("rst_mode",   A_MODE,   32'h0000_0000);

        // Fixed priority: sources 2 and 8 pending, 2 wins
        i_irq_status = 32'h0000_0104;
        check("irq_before_edge", {31'd0, o_irq}, 32'd0);
        tick();
        check("irq_pend", {31'd0, o_irq}, 32'd1);
        wb_read("claim_2", A_IRQ_CLAIM, 32'h8000_0002);
        check("irq_in_service", {31'd0, o_irq}, 32'd0);
        wb_read("claim_in_service", A_IRQ_CLAIM, 32'h0000_0000);

        // Mismatched EOI flags ERR and keeps the class in service
        wb_write("eoi_bad", A_IRQ_EOI, 32'd5);
        check("irq_after_bad_eoi", {31'd0, o_irq}, 32'd0);
        wb_read("status_err", A_STATUS, 32'h0001_0022);
        wb_write("err_clr", A_ERR_CLR, 32'd0);
        wb_read("status_err_clr", A_STATUS, 32'h0000_0022);

        // Handler cleared source 2; correct EOI returns to IDLE, source 8 next
        i_irq_status = 32'h0000_0100;
        wb_write("eoi_2", A_IRQ_EOI, 32'd2);
        check("irq_idle_after_eoi", {31'd0, o_irq}, 32'd0);
        tick();
        check("irq_reassert", {31'd0, o_irq}, 32'd1);
        wb_read("claim_8", A_IRQ_CLAIM, 32'h8000_0008);
        i_irq_status = '0;
        wb_write("eoi_8", A_IRQ_EOI, 32'd8);
        tick();

        // Round-robin on sources 1 and 2
        wb_write("mode_rr", A_MODE, 32'd1);
        wb_read("mode_rd", A_MODE, 32'h0000_0001);
        i_irq_status = 32'h0000_0006;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_pend", {31'd0, o_irq}, 32'd1);
            wb_read("rr_claim", A_IRQ_CLAIM, {1'b1, 26'd0, rr_exp[k]});
            wb_write("rr_eoi", A_IRQ_EOI, {27'd0, rr_exp[k]});
        end
        i_irq_status = '0;
        tick();

        // One-cycle status pulse withdrawn before the claim
        i_irq_status = 32'h0000_0020;
        tick();
        i_irq_status = '0;
        check("pulse_high", {31'd0, o_irq}, 32'd1);
        tick();
        check("pulse_low", {31'd0, o_irq}, 32'd0);
        wb_read("pulse_claim", A_IRQ_CLAIM, 32'h0000_0000);

        // EOI while idle sets ERR; unmapped address
        wb_write("eoi_idle", A_IRQ_EOI, 32'd5);
        wb_read("unmapped", 32'h0000_0040, 32'h2233_4455);

        // IRQ in service (pointer is 3, so source 2 is reached by wrapping), FIRQ nests
        i_irq_status = 32'h0000_0004;
        tick();
        wb_read("claim_wrap", A_IRQ_CLAIM, 32'h8000_0002);
        i_firq_status = 32'h0000_0080;
        tick();
        check("nest_firq", {31'd0, o_firq}, 32'd1);
        check("nest_irq",  {31'd0, o_irq},  32'd0);
        wb_read("firq_claim", A_FIRQ_CLAIM, 32'h8000_0007);
        check("firq_in_service", {31'd0, o_firq}, 32'd0);
        wb_read("status_nest", A_STATUS, 32'h0001_0E2A);
        wb_write("err_clr2", A_ERR_CLR, 32'd0);
        wb_read("status_nest_clr", A_STATUS, 32'h0000_0E2A);

        // Reset during FIRQ service with the FIRQ source still asserted
        i_irq_status = '0;
        i_rst = 1'b1;
        tick();
        tick();
        check("rst_svc_firq", {31'd0, o_firq}, 32'd0);
        check("rst_svc_irq",  {31'd0, o_irq},  32'd0);
        i_rst = 1'b0;
        tick();
        check("post_rst_firq", {31'd0, o_firq}, 32'd1);
        check("post_rst_irq",  {31'd0, o_irq},  32'd0);
        wb_read("post_rst_mode",   A_MODE,   32'h0000_0000);
        wb_read("post_rst_status", A_STATUS, 32'h0000_0E04);

        // Clean reset with no sources: everything reads back zero
        i_firq_status = '0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        wb_read("final_status", A_STATUS,     32'h0000_0000);
        wb_read("final_fclaim", A_FIRQ_CLAIM, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
